b16_bus_fabric: RTL

//  Parametrised b16 system-bus fabric. Sits between the CPU/debug-muxed bus and the memory/SFR slaves.

---
 rtl/b16_bus_pkg.sv | 22 ++
 rtl/b16_wait_timer.sv | 41 ++++
 rtl/b16_bus_fabric.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/b16_bus_pkg.sv
// Shared types and constants for the b16 system-bus fabric.
package b16_bus_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bus_state_t;

    localparam int unsigned TMO_W = 8;
    localparam logic [TMO_W-1:0] TMO_DEFAULT = 8'd255;

    // Width of a slave index; never less than one bit so NSLV=1 still elaborates.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned bits;
        bits = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            bits++;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/b16_wait_timer.sv
// Wait-state down-counter and ack-timeout up-counter for one bus access at a time.
module b16_wait_timer
    import b16_bus_pkg::*;
#(
    parameter int unsigned      WS_W = 4,
    parameter logic [TMO_W-1:0] TMO  = TMO_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic [WS_W-1:0] i_load_val,
    input  logic            i_run,
    output logic            o_cnt_zero,
    output logic            o_tmo_hit
);

    logic [WS_W-1:0]  r_cnt;
    logic [TMO_W-1:0] r_tmo;

    assign o_cnt_zero = (r_cnt == '0);
    assign o_tmo_hit  = (r_tmo == TMO);

    // Both counters saturate so a stalled access never wraps back into range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_tmo <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
            r_tmo <= '0;
        end else if (i_run) begin
            if (!o_cnt_zero) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (!o_tmo_hit) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

endmodule

// File: rtl/b16_bus_fabric.sv
// b16 system-bus fabric: address decode, per-slave wait/ack sequencing with timeout,
// CPU ready gate and read-data mux.
module b16_bus_fabric
    import b16_bus_pkg::*;
#(
    parameter int unsigned          NSLV    = 4,
    parameter int unsigned          AW      = 16,
    parameter int unsigned          DW      = 16,
    parameter int unsigned          WS_W    = 4,
    parameter logic [NSLV*AW-1:0]   BASE    = '0,
    parameter logic [NSLV*AW-1:0]   MASK    = '0,
    parameter logic [NSLV*WS_W-1:0] WAIT    = '0,
    parameter logic [NSLV-1:0]      ACKMODE = '0,
    parameter logic [TMO_W-1:0]     TMO     = TMO_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AW-1:0]        addr,
    input  logic                 r,
    input  logic [1:0]           w,
    output logic [NSLV-1:0]      sel,
    input  logic [NSLV*DW-1:0]   slv_rdata,
    input  logic [NSLV-1:0]      slv_ack,
    output logic [DW-1:0]        rdata,
    output logic                 ready,
    output logic                 wstb,
    output logic                 err,
    output logic                 err_flag,
    input  logic                 err_clr
);

    localparam int unsigned SIW = clog2_min1(NSLV);

    bus_state_t              r_state;
    bus_state_t              w_next;
    logic [NSLV-1:0]         w_hit;
    logic [NSLV-1:0]         w_first;
    logic [NSLV:0]           w_seen;
    logic [NSLV:0][DW-1:0]   w_rd_chain;
    logic [SIW-1:0]          w_sidx;
    logic [WS_W-1:0]         w_wait;
    logic [WS_W-1:0]         w_load_val;
    logic                    w_ackm;
    logic                    w_ack;
    logic                    w_req;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_load;
    logic                    w_run;
    logic                    w_cnt_zero;
    logic                    w_tmo_hit;

    assign w_seen[0]     = 1'b0;
    assign w_rd_chain[0] = '0;

    // Priority chain: a slave is selected only if no lower index already hit.
    for (genvar i = 0; i < NSLV; i++) begin : g_slv
        assign w_hit[i]        = ((addr ^ BASE[i*AW +: AW]) & MASK[i*AW +: AW]) == '0;
        assign w_first[i]      = w_hit[i] & ~w_seen[i];
        assign w_seen[i+1]     = w_seen[i] | w_hit[i];
        assign w_rd_chain[i+1] = w_rd_chain[i] | (slv_rdata[i*DW +: DW] & {DW{sel[i]}});
    end

    always_comb begin
        sel         = w_first;
        sel[NSLV-1] = w_first[NSLV-1] | ~w_seen[NSLV];
    end

    always_comb begin
        w_sidx = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (sel[i]) begin
                w_sidx = SIW'(i);
            end
        end
    end

    assign w_wait     = WAIT[w_sidx*WS_W +: WS_W];
    assign w_ackm     = ACKMODE[w_sidx];
    assign w_ack      = slv_ack[w_sidx];
    assign w_load_val = w_ackm ? '0 : (w_wait - 1'b1);

    assign w_wr  = |w;
    assign w_req = r | w_wr;
    assign w_rd  = r & ~w_wr;

    b16_wait_timer #(
        .WS_W (WS_W),
        .TMO  (TMO)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_run      (w_run),
        .o_cnt_zero (w_cnt_zero),
        .o_tmo_hit  (w_tmo_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        err    = 1'b0;
        w_load = 1'b0;
        w_run  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_req) begin
                    ready = 1'b1;
                end else if ((w_wait == '0) && !w_ackm) begin
                    ready = 1'b1;
                end else begin
                    w_load = 1'b1;
                    w_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!w_req) begin
                    w_next = ST_IDLE;
                end else begin
                    w_run = 1'b1;
                    if (w_ackm) begin
                        // An ack arriving on the timeout cycle still counts as a completion.
                        if (w_ack) begin
                            ready = 1'b1;
                        end else if (w_tmo_hit) begin
                            ready = 1'b1;
                            err   = 1'b1;
                        end
                    end else begin
                        ready = w_cnt_zero;
                    end
                    if (ready) begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // A write byte-enable is live in every cycle it is held: it starts, continues or ends an access.
    assign wstb  = w_wr;
    assign rdata = (w_rd & ready & ~err) ? w_rd_chain[NSLV] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flag <= 1'b0;
        end else if (err) begin
            err_flag <= 1'b1;
        end else if (err_clr) begin
            err_flag <= 1'b0;
        end
    end

endmodule
